dcache_ram_responder: RTL and testbench
=======================================

Name: dcache_ram_responder

Overview:
- Memory-side responder for the dcache RAM interface: serves line refills (rd_req → 4 returned words) and dirty-line writebacks (128-bit line → 4 word writes).
- Sits between the dcache RAM port and a single-port synchronous word SRAM with 1-cycle read latency.
- Read data reaches the cache as 4 numbered 32-bit beats.

Parameters:
MEM_AW, 16, SRAM word-address width; byte address bits [MEM_AW+1:2] are used, higher bits are ignored.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
ram_rd_req_i  in  1  refill request (level), from cache
ram_rd_addr_i  in  32  refill byte address; bits [3:0] ignored (line aligned)
ram_rd_rdy_o  out  1  one beat of refill data valid this cycle
ram_rd_data_o  out  32  refill beat data
ram_rd_num_o  out  3  beat index 0..3, valid with ram_rd_rdy_o
ram_wr_rdy_o  out  1  responder can accept a writeback
ram_wr_req_i  in  1  writeback request (one-cycle pulse)
ram_wr_addr_i  in  32  writeback byte address; bits [3:0] ignored
ram_wr_data_i  in  128  writeback line; word k = bits [32k+31:32k]
ram_dirty_i  in  1  line dirty; qualifies ram_wr_req_i
mem_en_o  out  1  SRAM access enable
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  MEM_AW  SRAM word address
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, valid one cycle after the enabled read

Behaviour:
Reset and outputs
- Async reset forces state IDLE and all outputs to 0, including ram_wr_rdy_o.
- All outputs are registered.
- ram_wr_rdy_o goes to 1 at the first clk edge after rst_n deasserts.

States
- IDLE, WRITE, READ, DRAIN, HOLD.
- Beat counter cnt[1:0].
- Latched line base = addr[MEM_AW+1:4].
- 128-bit write buffer.

Acceptance (IDLE only)
- At an edge with ram_wr_req_i & ram_wr_rdy_o & ram_dirty_i: latch addr and data, go to WRITE, drop ram_wr_rdy_o.
- At an edge with ram_wr_req_i & ram_wr_rdy_o & !ram_dirty_i: accept and discard; no SRAM access; stay IDLE.
- At an edge with ram_rd_req_i and no accepted write: latch addr, go to READ, drop ram_wr_rdy_o.
- Write and read requested at the same edge: the write wins; the read stays pending because the cache holds ram_rd_req_i.

WRITE (cycles C1..C4 after the acceptance edge)
- mem_en_o=1, mem_we_o=1, mem_addr_o={base,cnt}, mem_wdata_o = buffer word cnt, with cnt = 0..3.
- After C4: return to IDLE; ram_wr_rdy_o=1 from C5.

READ
- C1..C4: mem_en_o=1, mem_we_o=0, mem_addr_o={base,cnt}.
- Each returned word is registered into ram_rd_data_o.
- ram_rd_rdy_o=1 and ram_rd_num_o=k in cycle C(k+3), so beats 0..3 appear in C3..C6, contiguous.
- C5..C6: state DRAIN, SRAM idle.
- C7: state HOLD. ram_rd_req_i is ignored for this one cycle so the cache can drop it after beat 3.
- C8: IDLE; ram_wr_rdy_o=1.

Ordering and behaviour while busy
- A read of a line written by a completed writeback returns the new data.
- ram_rd_req_i and ram_wr_req_i are ignored outside IDLE.
- The cache must not pulse ram_wr_req_i while ram_wr_rdy_o=0; any such pulse is dropped.
- ram_rd_rdy_o is 0 in every cycle not listed above; ram_rd_data_o holds its last value.

Reset mid-operation
- Aborts immediately; no further SRAM accesses or beats.
- After release the block behaves as freshly reset.

Address rules
- Beat k targets word address {addr[MEM_AW+1:4], k[1:0]}; no wrap beyond the line.
- Bits [31:MEM_AW+2] are ignored (aliasing allowed).

Test Plan:
1. Preload SRAM words 0x40..0x43 = 11111111, 22222222, 33333333, 44444444; rd_req with addr 0x00000100 → beats in C3..C6, num 0..3, data 11111111..44444444; mem_en_o=1 only in C1..C4; ram_wr_rdy_o=0 through C7.
2. wr_req pulse with dirty=1, addr 0x00000200, data 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → SRAM words 0x80..0x83 = AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD with mem_we_o=1 in C1..C4; ram_wr_rdy_o back to 1 in C5.
3. wr_req (dirty=1, addr 0x300, new data) and rd_req (addr 0x300) at the same edge → 4 writes first, then the read returns the new data beats 0..3.
4. wr_req pulse with dirty=0 → no mem_en_o; ram_wr_rdy_o stays 1.
5. rd_req held high through HOLD, then dropped → exactly one burst of 4 beats, no second acceptance.
6. Assert rst_n=0 during read cycle C4 → all outputs 0 immediately; after release, ram_wr_rdy_o=1 after one edge and no stale beats appear.

Source files
------------

// File: rtl/dcache_ram_responder_if.sv
// Cache-side RAM port of the dcache: refill reads and dirty-line writebacks.
// Signal suffixes are relative to the responder (slave).
interface dcache_ram_responder_if;
  logic         ram_rd_req_i;
  logic [31:0]  ram_rd_addr_i;
  logic         ram_rd_rdy_o;
  logic [31:0]  ram_rd_data_o;
  logic [2:0]   ram_rd_num_o;
  logic         ram_wr_rdy_o;
  logic         ram_wr_req_i;
  logic [31:0]  ram_wr_addr_i;
  logic [127:0] ram_wr_data_i;
  logic         ram_dirty_i;

  modport slave (
    input  ram_rd_req_i, ram_rd_addr_i, ram_wr_req_i, ram_wr_addr_i,
           ram_wr_data_i, ram_dirty_i,
    output ram_rd_rdy_o, ram_rd_data_o, ram_rd_num_o, ram_wr_rdy_o
  );

  modport master (
    output ram_rd_req_i, ram_rd_addr_i, ram_wr_req_i, ram_wr_addr_i,
           ram_wr_data_i, ram_dirty_i,
    input  ram_rd_rdy_o, ram_rd_data_o, ram_rd_num_o, ram_wr_rdy_o
  );
endinterface

// File: rtl/dcache_ram_responder.sv
// Memory-side responder: serves 4-word line refills and line writebacks
// against a single-port word SRAM with one cycle of read latency.
module dcache_ram_responder #(
  parameter int MEM_AW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dcache_ram_responder_if.slave  ram,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [MEM_AW-1:0]      mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  input  logic [31:0]            mem_rdata_i
);

  localparam int BW = MEM_AW - 2;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [BW-1:0]     base_q, base_d;
  logic [127:0]      buf_q, buf_d;
  logic              wr_rdy_q, wr_rdy_d;
  logic              rd_rdy_q, rd_rdy_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [2:0]        rd_num_q, rd_num_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rd_vld_q, rd_vld_d;
  logic [1:0]        rd_idx_q, rd_idx_d;
  logic              issue, issue_we;
  logic [6:0]        wsel;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    buf_d       = buf_q;
    wr_rdy_d    = wr_rdy_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    issue       = 1'b0;
    issue_we    = 1'b0;
    wsel        = 7'd0;
    // Read data returns the cycle after an enabled read; register it as a beat.
    rd_vld_d    = mem_en_q & ~mem_we_q;
    rd_idx_d    = mem_addr_q[1:0];
    rd_rdy_d    = rd_vld_q;
    rd_data_d   = rd_vld_q ? mem_rdata_i : rd_data_q;
    rd_num_d    = rd_vld_q ? {1'b0, rd_idx_q} : rd_num_q;

    case (state_q)
      S_IDLE: begin
        wr_rdy_d = 1'b1;
        if (ram.ram_wr_req_i && wr_rdy_q && ram.ram_dirty_i) begin
          state_d  = S_WRITE;
          base_d   = ram.ram_wr_addr_i[MEM_AW+1:4];
          buf_d    = ram.ram_wr_data_i;
          cnt_d    = 2'd0;
          wr_rdy_d = 1'b0;
          issue    = 1'b1;
          issue_we = 1'b1;
        end else if (ram.ram_rd_req_i) begin
          state_d  = S_READ;
          base_d   = ram.ram_rd_addr_i[MEM_AW+1:4];
          cnt_d    = 2'd0;
          wr_rdy_d = 1'b0;
          issue    = 1'b1;
        end
      end
      S_WRITE, S_READ: begin
        if (cnt_q == 2'd3) begin
          cnt_d = 2'd0;
          if (state_q == S_WRITE) begin
            state_d  = S_IDLE;
            wr_rdy_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          cnt_d    = cnt_q + 2'd1;
          issue    = 1'b1;
          issue_we = (state_q == S_WRITE);
        end
      end
      S_DRAIN: begin
        if (cnt_q == 2'd1) begin
          state_d = S_HOLD;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_HOLD: begin
        state_d  = S_IDLE;
        wr_rdy_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      mem_en_d   = 1'b1;
      mem_we_d   = issue_we;
      mem_addr_d = {base_d, cnt_d};
      if (issue_we) begin
        wsel        = {cnt_d, 5'd0};
        mem_wdata_d = buf_d[wsel +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      buf_q       <= '0;
      wr_rdy_q    <= 1'b0;
      rd_rdy_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_num_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      buf_q       <= buf_d;
      wr_rdy_q    <= wr_rdy_d;
      rd_rdy_q    <= rd_rdy_d;
      rd_data_q   <= rd_data_d;
      rd_num_q    <= rd_num_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  assign ram.ram_wr_rdy_o  = wr_rdy_q;
  assign ram.ram_rd_rdy_o  = rd_rdy_q;
  assign ram.ram_rd_data_o = rd_data_q;
  assign ram.ram_rd_num_o  = rd_num_q;
  assign mem_en_o          = mem_en_q;
  assign mem_we_o          = mem_we_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wdata_o       = mem_wdata_q;

  // Address bits outside the SRAM window and the line offset alias away.
  logic unused_bits;
  assign unused_bits = ^{ram.ram_rd_addr_i[31:MEM_AW+2], ram.ram_rd_addr_i[3:0],
                         ram.ram_wr_addr_i[31:MEM_AW+2], ram.ram_wr_addr_i[3:0]};

endmodule

// File: tb/tb_dcache_ram_responder.sv
// Directed bench for dcache_ram_responder with a behavioural SRAM and
// queue-based scoreboards for refill beats and SRAM writes.
module tb_dcache_ram_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        pl_en;
  logic [15:0] pl_addr;
  logic [31:0] pl_data;
  logic [31:0] sram [0:65535];

  int tests;
  int fails;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  n;
  } beat_t;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  beat_t exp_rd [$];
  wr_t   exp_wr [$];
  logic [31:0] exp_mem [int unsigned];

  dcache_ram_responder_if rif ();

  dcache_ram_responder #(.MEM_AW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ram         (rif),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rif.ram_rd_rdy_o === 1'b1) begin
        chk("beat_expected", {127'd0, exp_rd.size() != 0}, 128'd1);
        if (exp_rd.size() != 0) begin
          beat_t b;
          b = exp_rd.pop_front();
          chk("beat_data", {96'd0, rif.ram_rd_data_o}, {96'd0, b.d});
          chk("beat_num", {125'd0, rif.ram_rd_num_o}, {125'd0, b.n});
        end
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        chk("write_expected", {127'd0, exp_wr.size() != 0}, 128'd1);
        if (exp_wr.size() != 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write_addr", {112'd0, mem_addr}, {112'd0, w.a});
          chk("write_data", {96'd0, mem_wdata}, {96'd0, w.d});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    exp_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [127:0] line);
    for (int k = 0; k < 4; k++) begin
      wr_t w;
      w.a = {addr[15:4], 2'(k)};
      w.d = line[32*k +: 32];
      exp_wr.push_back(w);
      exp_mem[w.a] = w.d;
    end
  endtask

  task automatic push_rd(input logic [31:0] addr, input int n);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      logic [15:0] wa;
      wa  = {addr[15:4], 2'(k)};
      b.d = exp_mem[wa];
      b.n = 3'(k);
      exp_rd.push_back(b);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_rdy"},  {127'd0, rif.ram_wr_rdy_o}, 128'd0);
    chk({tag, "_rd_rdy"},  {127'd0, rif.ram_rd_rdy_o}, 128'd0);
    chk({tag, "_rd_data"}, {96'd0, rif.ram_rd_data_o}, 128'd0);
    chk({tag, "_rd_num"},  {125'd0, rif.ram_rd_num_o}, 128'd0);
    chk({tag, "_mem_en"},  {127'd0, mem_en}, 128'd0);
    chk({tag, "_mem_we"},  {127'd0, mem_we}, 128'd0);
    chk({tag, "_mem_addr"}, {112'd0, mem_addr}, 128'd0);
    chk({tag, "_mem_wdata"}, {96'd0, mem_wdata}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n;
    tests = 0;
    fails = 0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    rif.ram_rd_req_i  = 1'b0;
    rif.ram_rd_addr_i = '0;
    rif.ram_wr_req_i  = 1'b0;
    rif.ram_wr_addr_i = '0;
    rif.ram_wr_data_i = '0;
    rif.ram_dirty_i   = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    preload(16'h0040, 32'h11111111);
    preload(16'h0041, 32'h22222222);
    preload(16'h0042, 32'h33333333);
    preload(16'h0043, 32'h44444444);
    chk_all_zero("reset");

    rst_n = 1'b1;
    chk("wr_rdy_before_edge", {127'd0, rif.ram_wr_rdy_o}, 128'd0);
    step();
    chk("wr_rdy_after_edge", {127'd0, rif.ram_wr_rdy_o}, 128'd1);

    // Test 1: plain refill
    push_rd(32'h0000_0100, 4);
    rif.ram_rd_addr_i = 32'h0000_0100;
    rif.ram_rd_req_i  = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t1_mem_en_c%0d", k), {127'd0, mem_en}, {127'd0, k <= 4});
      chk($sformatf("t1_mem_we_c%0d", k), {127'd0, mem_we}, 128'd0);
      chk($sformatf("t1_rd_rdy_c%0d", k), {127'd0, rif.ram_rd_rdy_o}, {127'd0, k >= 3 && k <= 6});
      chk($sformatf("t1_wr_rdy_c%0d", k), {127'd0, rif.ram_wr_rdy_o}, {127'd0, k == 8});
      if (k == 7) rif.ram_rd_req_i = 1'b0;
      if (k < 8) step();
    end
    step();
    chk("t1_no_reaccept", {127'd0, mem_en}, 128'd0);

    // Test 2: dirty writeback
    push_wr(32'h0000_0200, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    rif.ram_wr_addr_i = 32'h0000_0200;
    rif.ram_wr_data_i = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    rif.ram_dirty_i   = 1'b1;
    rif.ram_wr_req_i  = 1'b1;
    step();
    rif.ram_wr_req_i  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("t2_mem_we_c%0d", k), {127'd0, mem_we}, {127'd0, k <= 4});
      chk($sformatf("t2_mem_en_c%0d", k), {127'd0, mem_en}, {127'd0, k <= 4});
      chk($sformatf("t2_wr_rdy_c%0d", k), {127'd0, rif.ram_wr_rdy_o}, {127'd0, k == 5});
      if (k < 5) step();
    end

    // Test 3: simultaneous write and read of the same line
    push_wr(32'h0000_0300, 128'h44440003_33330002_22220001_11110000);
    push_rd(32'h0000_0300, 4);
    rif.ram_wr_addr_i = 32'h0000_0300;
    rif.ram_wr_data_i = 128'h44440003_33330002_22220001_11110000;
    rif.ram_dirty_i   = 1'b1;
    rif.ram_wr_req_i  = 1'b1;
    rif.ram_rd_addr_i = 32'h0000_0300;
    rif.ram_rd_req_i  = 1'b1;
    step();
    rif.ram_wr_req_i  = 1'b0;
    n = 0;
    while (!(rif.ram_rd_rdy_o === 1'b1 && rif.ram_rd_num_o === 3'd3) && n < 40) begin
      step();
      n++;
    end
    chk("t3_burst_seen", {127'd0, n < 40}, 128'd1);
    chk("t3_burst_latency", n, 128'd10);
    step();
    rif.ram_rd_req_i = 1'b0;
    chk("t3_hold_wr_rdy", {127'd0, rif.ram_wr_rdy_o}, 128'd0);
    step();
    chk("t3_idle_wr_rdy", {127'd0, rif.ram_wr_rdy_o}, 128'd1);

    // Test 4: clean line writeback is discarded
    rif.ram_wr_addr_i = 32'h0000_0400;
    rif.ram_wr_data_i = 128'h1;
    rif.ram_dirty_i   = 1'b0;
    rif.ram_wr_req_i  = 1'b1;
    step();
    rif.ram_wr_req_i  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t4_mem_en_c%0d", k), {127'd0, mem_en}, 128'd0);
      chk($sformatf("t4_wr_rdy_c%0d", k), {127'd0, rif.ram_wr_rdy_o}, 128'd1);
      step();
    end

    // Test 5: rd_req held through HOLD then dropped
    push_rd(32'h0000_0200, 4);
    rif.ram_rd_addr_i = 32'h0000_0200;
    rif.ram_rd_req_i  = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t5_wr_rdy_c%0d", k), {127'd0, rif.ram_wr_rdy_o}, {127'd0, k == 8});
      if (k == 8) rif.ram_rd_req_i = 1'b0;
      step();
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t5_quiet_%0d", k), {126'd0, mem_en, rif.ram_rd_rdy_o}, 128'd0);
      step();
    end

    // Test 6: reset during read C4
    push_rd(32'h0000_0100, 1);
    rif.ram_rd_addr_i = 32'h0000_0100;
    rif.ram_rd_req_i  = 1'b1;
    step();
    step();
    step();
    step();
    rst_n = 1'b0;
    rif.ram_rd_req_i = 1'b0;
    #1;
    chk_all_zero("t6_abort");
    step();
    step();
    rst_n = 1'b1;
    chk("t6_wr_rdy_before_edge", {127'd0, rif.ram_wr_rdy_o}, 128'd0);
    step();
    chk("t6_wr_rdy_after_edge", {127'd0, rif.ram_wr_rdy_o}, 128'd1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t6_quiet_%0d", k), {126'd0, mem_en, rif.ram_rd_rdy_o}, 128'd0);
      step();
    end

    chk("rd_queue_empty", exp_rd.size(), 128'd0);
    chk("wr_queue_empty", exp_wr.size(), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
